// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator: saturating accumulation of N_TERMS signed products with valid/ready input and held result
module booth_product_accumulator #(
  parameter int PROD_W  = 8,
  parameter int ACC_W   = 12,
  parameter int N_TERMS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ack,
  output logic              overflow,
  output logic              busy
);
  localparam int CW = N_TERMS > 1 ? $clog2(N_TERMS) : 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [ACC_W:0]   sum;
  logic             sat_hi, sat_lo, xfer;
  always_comb begin
    sum        = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-PROD_W){prod_in[PROD_W-1]}}, prod_in};
    sat_hi     = !sum[ACC_W] && sum[ACC_W-1];
    sat_lo     = sum[ACC_W] && !sum[ACC_W-1];
    xfer       = state_q == ACCUM && prod_valid;
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (state_q == IDLE && start) begin
      state_d    = ACCUM;
      acc_d      = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
    if (xfer) begin
      acc_d      = sat_hi ? ACC_MAX : sat_lo ? ACC_MIN : sum[ACC_W-1:0];
      overflow_d = overflow_q || sat_hi || sat_lo;
      count_d    = count_q + CW'(1);
      state_d    = count_q == CW'(N_TERMS-1) ? HOLD : ACCUM;
    end
    if (state_q == HOLD && acc_ack) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end
  assign prod_ready = state_q == ACCUM;
  assign acc_valid  = state_q == HOLD;
  assign busy       = state_q != IDLE;
  assign acc_out    = acc_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_booth_product_accumulator.sv
// tb_booth_product_accumulator: scoreboard bench driving a 12-bit and an 8-bit accumulator with shared stimulus
module tb_booth_product_accumulator;
  logic clk = 0, rst_n = 0, start = 0, prod_valid = 0, acc_ack = 0;
  logic [7:0] prod_in = '0;
  logic rdy_a, va, ovf_a, busy_a, rdy_b, vb, ovf_b, busy_b;
  logic [11:0] acc_a;
  logic [7:0] acc_b;
  int vectors = 0, miscompares = 0;
  typedef struct {int acc; bit ovf;} exp_t;
  exp_t qa[$], qb[$];
  bit va_prev = 0, vb_prev = 0;

  booth_product_accumulator dut_a (.clk(clk), .rst_n(rst_n), .start(start), .prod_in(prod_in),
    .prod_valid(prod_valid), .prod_ready(rdy_a), .acc_out(acc_a), .acc_valid(va),
    .acc_ack(acc_ack), .overflow(ovf_a), .busy(busy_a));
  booth_product_accumulator #(.ACC_W(8)) dut_b (.clk(clk), .rst_n(rst_n), .start(start), .prod_in(prod_in),
    .prod_valid(prod_valid), .prod_ready(rdy_b), .acc_out(acc_b), .acc_valid(vb),
    .acc_ack(acc_ack), .overflow(ovf_b), .busy(busy_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input int p[$], input int w, output int acc, output bit ovf);
    int mx = (1 << (w - 1)) - 1;
    int mn = -(1 << (w - 1));
    acc = 0;
    ovf = 0;
    foreach (p[i]) begin
      acc += p[i];
      if (acc > mx) begin acc = mx; ovf = 1; end
      else if (acc < mn) begin acc = mn; ovf = 1; end
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (va && !va_prev) begin
      if (qa.size() == 0) chk("mon12_unexpected_valid", 1, 0);
      else begin
        e = qa.pop_front();
        chk("mon12_acc", int'($signed(acc_a)), e.acc);
        chk("mon12_ovf", int'(ovf_a), int'(e.ovf));
      end
    end
    if (vb && !vb_prev) begin
      if (qb.size() == 0) chk("mon8_unexpected_valid", 1, 0);
      else begin
        e = qb.pop_front();
        chk("mon8_acc", int'($signed(acc_b)), e.acc);
        chk("mon8_ovf", int'(ovf_b), int'(e.ovf));
      end
    end
    va_prev = va;
    vb_prev = vb;
  end

  task automatic idle_checks(input string tag);
    chk({tag, "_acc12"}, int'(acc_a), 0);
    chk({tag, "_acc8"}, int'(acc_b), 0);
    chk({tag, "_ovf8"}, int'(ovf_b), 0);
    chk({tag, "_valid"}, int'(va | vb), 0);
    chk({tag, "_ready"}, int'(rdy_a | rdy_b), 0);
    chk({tag, "_busy"}, int'(busy_a | busy_b), 0);
  endtask

  task automatic run(input int p[$], input int gap, input bit early, input bit ack_start);
    int e12, e8;
    bit o12, o8;
    model(p, 12, e12, o12);
    model(p, 8, e8, o8);
    qa.push_back('{e12, o12});
    qb.push_back('{e8, o8});
    start = 1;
    @(posedge clk); #1 start = 0;
    chk("start_busy", int'(busy_a & busy_b), 1);
    chk("start_acc_clr", int'(acc_b), 0);
    chk("start_ovf_clr", int'(ovf_b), 0);
    foreach (p[i]) begin
      chk("accum_ready", int'(rdy_a & rdy_b), 1);
      chk("accum_no_valid", int'(va | vb), 0);
      prod_in = 8'(p[i]);
      prod_valid = 1;
      if (early && i == p.size() - 1) acc_ack = 1;
      @(posedge clk); #1 prod_valid = 0;
      if (i < p.size() - 1) begin
        repeat (gap) begin
          start = 1'($urandom_range(0, 1));
          prod_in = 8'($urandom);
          @(posedge clk); #1;
        end
        start = 0;
      end
    end
    chk("hold_ready_low", int'(rdy_a | rdy_b), 0);
    chk("hold_valid", int'(va & vb), 1);
    if (!early) begin
      prod_valid = 1;
      prod_in = 8'd64;
      start = 1;
      repeat (2) @(posedge clk);
      #1 chk("hold_acc12_stable", int'($signed(acc_a)), e12);
      chk("hold_acc8_stable", int'($signed(acc_b)), e8);
      chk("hold_valid_kept", int'(va & vb), 1);
      prod_valid = 0;
      start = ack_start;
      acc_ack = 1;
      @(posedge clk); #1;
      start = 0;
    end else begin
      @(posedge clk); #1;
    end
    acc_ack = 0;
    chk("ack_valid_low", int'(va | vb), 0);
    chk("ack_busy_low", int'(busy_a | busy_b), 0);
    chk("idle_acc12_hold", int'($signed(acc_a)), e12);
    chk("idle_ovf8_hold", int'(ovf_b), int'(o8));
    @(posedge clk); #1;
    chk("no_new_run", int'(busy_a | busy_b), 0);
  endtask

  initial begin
    int p[$];
    #3 idle_checks("reset");
    #20 rst_n = 1;
    @(posedge clk); #1;
    run('{-21, 15, 49, -64}, 0, 0, 0);
    run('{-21, 15, 49, -64}, 3, 0, 1);
    run('{64, 64, -8, 1}, 0, 0, 0);
    run('{-56, -56, -56, 10}, 1, 1, 1);
    start = 1;
    @(posedge clk); #1 start = 0;
    repeat (2) begin
      prod_in = 8'd64;
      prod_valid = 1;
      @(posedge clk); #1 prod_valid = 0;
    end
    chk("partial_ovf8", int'(ovf_b), 1);
    #2 rst_n = 0;
    #1 idle_checks("midrun_reset");
    @(posedge clk); #1 rst_n = 1;
    run('{-21, 15, 49, -64}, 0, 0, 0);
    for (int r = 0; r < 30; r++) begin
      p = {};
      for (int k = 0; k < 4; k++) p.push_back(int'($urandom_range(0, 255)) - 128);
      run(p, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (2) @(posedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/booth_product_accumulator.md
Name: booth_product_accumulator

Overview:
- Downstream consumer of the 4x4 signed Booth multiplier. It takes its 8-bit two's-complement product (AQ) and accumulates N_TERMS products into a dot-product result.
- Valid/ready handshake on the product input; result is held until acknowledged.
- Saturating accumulation with a sticky overflow flag; sits between the multiplier and the result register/bus.

Parameters:
PROD_W, 8, width of signed product input (matches multiplier AQ width)
ACC_W, 12, width of signed accumulator/result; must be >= PROD_W
N_TERMS, 4, products per accumulation run; >= 1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a new run; sampled only in IDLE
prod_in  input  PROD_W  signed product from multiplier
prod_valid  input  1  prod_in valid this cycle
prod_ready  output  1  block accepts prod_in this cycle
acc_out  output  ACC_W  signed accumulated result (meaningful when acc_valid=1)
acc_valid  output  1  result available and held
acc_ack  input  1  consumer takes result
overflow  output  1  sticky: saturation occurred during the current/last run
busy  output  1  high in ACCUM and HOLD

Behaviour:
- Reset (rst_n=0, async): state=IDLE; acc_out=0, count=0, overflow=0, acc_valid=0, prod_ready=0, busy=0. Applies immediately, including mid-run; a partial sum is discarded.
- All outputs are registered or decoded from registered state only. No combinational path from prod_valid or acc_ack to any output.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - prod_ready=0, acc_valid=0; acc_out and overflow hold the previous run's values.
  - start=1 → next cycle: acc_out=0, count=0, overflow=0, state=ACCUM.
- ACCUM:
  - prod_ready=1, busy=1.
  - Transfer occurs when prod_valid & prod_ready. On a transfer, acc_out <= sat(acc_out + sign_extend(prod_in)) and count++.
  - prod_valid=0: no change; waits indefinitely.
  - Transfer with count==N_TERMS-1 → state=HOLD next cycle, so exactly N_TERMS products are accepted. prod_ready is 0 from the following cycle.
- HOLD:
  - acc_valid=1, prod_ready=0; acc_out is stable.
  - acc_ack=1 → state=IDLE next cycle, acc_valid=0 that cycle.
  - acc_ack=1 in the same cycle acc_valid first rises is legal and is honoured.
- start outside IDLE is ignored, including start with acc_ack in HOLD. A new run needs start while in IDLE, so there is at least 1 idle cycle between runs.
- Arithmetic:
  - Full sum is computed at ACC_W+1 bits.
  - If the sum is > 2^(ACC_W-1)-1, clamp to the max value; if it is < -2^(ACC_W-1), clamp to the min value. Either clamp sets overflow=1.
  - overflow stays set until the next start. Later terms continue from the clamped value.
- Latency: acc_valid rises 1 cycle after the final product transfer. Minimum run is N_TERMS+2 cycles from start to acc_valid.
- N_TERMS=1: the first transfer goes directly to HOLD.

Test Plan:
- Reset mid-run: start, accept 2 products, assert rst_n=0 asynchronously → outputs 0 and IDLE immediately, before the next clk edge; next run's result is unaffected by the partial sum.
- Basic dot product (defaults): start, then products -21, 15, 49, -64 on consecutive cycles → prod_ready drops after the 4th; acc_valid=1 next cycle with acc_out=-21 (0xFEB); overflow=0; held until acc_ack, acc_valid=0 the cycle after ack.
- Backpressure/gaps: same 4 products with prod_valid low 3 cycles between each → identical result -21; count advances only on transfers; prod_valid in HOLD with value 64 is not accepted (acc_out still -21).
- Saturation (ACC_W=8): products 64, 64, -8, 1 → after 2nd term clamps to 127, overflow=1; final acc_out=120, overflow=1; next start clears overflow to 0.
- Negative saturation (ACC_W=8): -56, -56, -56, 10 → clamps to -128 at 3rd term; final acc_out=-118, overflow=1.
- Control corner cases: start asserted during ACCUM and HOLD is ignored (count unchanged); acc_ack with start in HOLD → IDLE, no new run; acc_ack held high across acc_valid rise → single-cycle valid.
